// File: rtl/image_downscale_2x_if.sv
// Pixel stream in, downscaled pixel stream out.
// master drives raster pixels; slave is the downscaler.
interface image_downscale_2x_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 9
);
    logic             horizontal_sync;
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;
    logic             out_valid;
    logic [7:0]       out_r;
    logic [7:0]       out_g;
    logic [7:0]       out_b;
    logic [COL_W-2:0] out_col;
    logic [ROW_W-2:0] out_row;
    logic             frame_done;

    modport master (
        output horizontal_sync,
        output r,
        output g,
        output b,
        input  out_valid,
        input  out_r,
        input  out_g,
        input  out_b,
        input  out_col,
        input  out_row,
        input  frame_done
    );

    modport slave (
        input  horizontal_sync,
        input  r,
        input  g,
        input  b,
        output out_valid,
        output out_r,
        output out_g,
        output out_b,
        output out_col,
        output out_row,
        output frame_done
    );
endinterface

// File: rtl/image_downscale_2x.sv
// 2:1 downscaler in both axes: rounded average of each 2x2 block,
// using a one-line buffer of horizontal pair sums.
module image_downscale_2x #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 9
) (
    input logic              horizontal_clock,
    input logic              horizontal_reset,
    image_downscale_2x_if.slave px
);
    localparam int HALF_W = WIDTH / 2;
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    typedef enum logic {
        S_EVEN,
        S_ODD
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic [7:0] hold_r_q, hold_r_d;
    logic [7:0] hold_g_q, hold_g_d;
    logic [7:0] hold_b_q, hold_b_d;

    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       out_r_q, out_r_d;
    logic [7:0]       out_g_q, out_g_d;
    logic [7:0]       out_b_q, out_b_d;
    logic [COL_W-2:0] out_col_q, out_col_d;
    logic [ROW_W-2:0] out_row_q, out_row_d;

    // Not reset: each entry is written on an even row before use.
    logic [26:0] line_mem [HALF_W];
    logic [26:0] line_rd;
    logic        line_we;
    logic [AW-1:0] addr;

    logic accept;
    logic odd_col;
    logic last_col;
    logic last_row;

    logic [8:0] sum_r, sum_g, sum_b;
    logic [9:0] tot_r, tot_g, tot_b;
    logic [9:0] rnd_r, rnd_g, rnd_b;
    logic [7:0] avg_r, avg_g, avg_b;

    assign accept   = px.horizontal_sync;
    assign odd_col  = col_q[0];
    assign last_col = (col_q == LAST_COL);
    assign last_row = (row_q == LAST_ROW);
    assign addr     = col_q[AW:1];

    assign sum_r = {1'b0, hold_r_q} + {1'b0, px.r};
    assign sum_g = {1'b0, hold_g_q} + {1'b0, px.g};
    assign sum_b = {1'b0, hold_b_q} + {1'b0, px.b};

    assign line_rd = line_mem[addr];

    assign tot_r = {1'b0, line_rd[26:18]} + {1'b0, sum_r};
    assign tot_g = {1'b0, line_rd[17:9]}  + {1'b0, sum_g};
    assign tot_b = {1'b0, line_rd[8:0]}   + {1'b0, sum_b};

    // Max total 1020, so +2 never wraps 10 bits.
    assign rnd_r = tot_r + 10'd2;
    assign rnd_g = tot_g + 10'd2;
    assign rnd_b = tot_b + 10'd2;

    assign avg_r = rnd_r[9:2];
    assign avg_g = rnd_g[9:2];
    assign avg_b = rnd_b[9:2];

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_r_d     = hold_r_q;
        hold_g_d     = hold_g_q;
        hold_b_d     = hold_b_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_r_d      = out_r_q;
        out_g_d      = out_g_q;
        out_b_d      = out_b_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        line_we      = 1'b0;

        if (accept) begin
            col_d = last_col ? '0 : col_q + 1'b1;

            if (!odd_col) begin
                hold_r_d = px.r;
                hold_g_d = px.g;
                hold_b_d = px.b;
            end

            unique case (state_q)
                S_EVEN: begin
                    line_we = odd_col;
                    if (last_col) begin
                        state_d = S_ODD;
                        row_d   = row_q + 1'b1;
                    end
                end
                S_ODD: begin
                    if (odd_col) begin
                        out_valid_d = 1'b1;
                        out_r_d     = avg_r;
                        out_g_d     = avg_g;
                        out_b_d     = avg_b;
                        out_col_d   = col_q[COL_W-1:1];
                        out_row_d   = row_q[ROW_W-1:1];
                    end
                    if (last_col) begin
                        state_d = S_EVEN;
                        if (last_row) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge horizontal_clock or posedge horizontal_reset) begin
        if (horizontal_reset) begin
            state_q      <= S_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            hold_r_q     <= '0;
            hold_g_q     <= '0;
            hold_b_q     <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_r_q      <= '0;
            out_g_q      <= '0;
            out_b_q      <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_r_q     <= hold_r_d;
            hold_g_q     <= hold_g_d;
            hold_b_q     <= hold_b_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            out_r_q      <= out_r_d;
            out_g_q      <= out_g_d;
            out_b_q      <= out_b_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
        end
    end

    always_ff @(posedge horizontal_clock) begin
        if (line_we) begin
            line_mem[addr] <= {sum_r, sum_g, sum_b};
        end
    end

    assign px.out_valid  = out_valid_q;
    assign px.frame_done = frame_done_q;
    assign px.out_r      = out_r_q;
    assign px.out_g      = out_g_q;
    assign px.out_b      = out_b_q;
    assign px.out_col    = out_col_q;
    assign px.out_row    = out_row_q;

endmodule

// File: doc/image_downscale_2x.md
Name: image_downscale_2x

Overview:
- Downstream consumer of the input master pixel stream.
- Takes raster-order RGB pixels, qualified by horizontal_sync high, and produces a 2:1 downscaled image in both axes by averaging each 2x2 block with rounding.
- Default 768x512 input gives 384x256 output.
- Holds a one-line buffer of horizontal pair sums; emits one output pixel per completed 2x2 block, in raster order, with its output coordinates.

Parameters:
- WIDTH, 768, input pixels per line; must be even.
- HEIGHT, 512, input lines per frame; must be even.
- COL_W, 10, width of the input column counter; must satisfy 2^COL_W >= WIDTH.
- ROW_W, 9, width of the input row counter; must satisfy 2^ROW_W >= HEIGHT.

Ports:
- horizontal_clock  input  1  sole clock, rising edge.
- horizontal_reset  input  1  asynchronous, active-high reset.
- horizontal_sync  input  1  pixel valid; r/g/b are sampled on every rising edge where it is high.
- r  input  8  red sample.
- g  input  8  green sample.
- b  input  8  blue sample.
- out_valid  output  1  one-cycle strobe; out_r/out_g/out_b/out_col/out_row are valid while it is high.
- out_r  output  8  averaged red.
- out_g  output  8  averaged green.
- out_b  output  8  averaged blue.
- out_col  output  COL_W-1  output column, 0..WIDTH/2-1.
- out_row  output  ROW_W-1  output row, 0..HEIGHT/2-1.
- frame_done  output  1  one-cycle pulse coincident with the final out_valid of a frame.

Behaviour:
- Reset (async, active-high):
  - col, row, state, pair-holding registers, out_valid, frame_done, out_* all go to 0; state = S_EVEN.
  - Line buffer RAM is not reset; its contents are don't-care because every location is written before it is read.
  - Reset asserted mid-frame abandons the frame; the next accepted pixel after deassertion is treated as (row 0, col 0).
- Counters:
  - col increments on each accepted pixel (horizontal_sync high) and wraps to 0 after WIDTH-1.
  - row increments when col wraps.
  - Cycles with horizontal_sync low are gaps, legal anywhere including mid-line: no counter, state or buffer change, and out_valid is 0 that cycle.
- Pair formation:
  - On an accepted pixel with even col, latch r/g/b into the hold registers.
  - On an accepted pixel with odd col, form the 9-bit sums hold+current for each channel.
- States:
  - S_EVEN (even input row): write the pair sums (27 bits total) to buffer[col>>1]; no output. On col == WIDTH-1, go to S_ODD.
  - S_ODD (odd input row):
    - Compute total = buffer[col>>1] + pair sum (10 bits per channel).
    - Output = (total + 2) >> 2, truncated to 8 bits; maximum 1022 >> 2 = 255, so no overflow.
    - Register the output values, out_col = col>>1, out_row = row>>1, and pulse out_valid.
    - On col == WIDTH-1: if row == HEIGHT-1, assert frame_done with that same out_valid and reset row to 0; otherwise go to S_EVEN.
- Latency: out_valid rises on the clock edge after the edge that accepts the odd-column pixel of an odd row (1 cycle). Buffer reads are combinational or prefetched so this latency holds with no gaps between input pixels.
- Throughput: one input pixel per clock, sustained. Output rate is at most one pixel every 2 clocks.
- Between frames: no explicit start signal. After frame_done the block is in S_EVEN at row 0, col 0, ready for the next frame.
- out_r/out_g/out_b/out_col/out_row hold their last value while out_valid is low.

Test Plan:
- Flat field: WIDTH=4, HEIGHT=4, every pixel r=10, g=20, b=30, streamed continuously from reset release -> exactly 4 out_valid pulses, each (10,20,30); coordinates (0,0), (1,0), (0,1), (1,1); frame_done only on the 4th pulse.
- Rounding: one 2x2 block with r = 1, 1, 1, 0 (total 3) -> out_r = 1. Block with r = 1, 1, 0, 0 (total 2) -> out_r = 1. Block all 255 -> out_r = 255. Block all 0 -> out_r = 0.
- Gaps: WIDTH=4, HEIGHT=2 with horizontal_sync low for 3 cycles between every pixel, plus 160-cycle gaps between lines -> same output values as the gapless run; out_valid never high during a gap.
- Reset mid-frame: assert horizontal_reset after row 1, col 2 of a 4x4 frame, then stream a full fresh frame -> outputs equal to a clean run; no spurious out_valid or frame_done from the abandoned frame.
- Default size: 768x512 ramp with r = col[7:0], g = row[7:0], b = 0 -> 98304 out_valid pulses. out_r at out_col c equals ((2c)+(2c+1))*2+2 >> 2, truncated to 8 bits; for c = 0 that is 1. Last pulse at (383,255) with frame_done high.
- Back-to-back frames: two 4x4 frames with no gap between them -> 8 outputs; frame_done on the 4th and 8th; the second frame's coordinates restart at (0,0).
